ins_mem_sync: RTL and testbench

- Parametrised, clocked successor to the combinational instruction memory.
- Single-cycle registered fetch port, byte-addressed by PC with alignment and range checking.
- Program-load write port for loading code at run time.
- After reset, a hardware clear sequencer zeroes the whole array before the block reports ready.
- Sits between the PC/fetch stage and the program loader.

---
 rtl/ins_mem_pkg.sv | 26 ++
 rtl/ins_mem_array.sv | 40 ++++
 rtl/ins_mem_sync.sv | 194 +++++++++++++++++++
 tb/tb_ins_mem_sync.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_mem_pkg.sv
// ---------------------------------------------------------------------------
// ins_mem_pkg
// Shared types and helpers for the synchronous instruction memory.
//   state_e     : clear-sequencer state (CLEAR after reset, RUN forever after)
//   fault_t     : 2-bit fetch fault code carried on fetch_fault
//   byte_off_w  : number of byte-offset bits inside one instruction word
// ---------------------------------------------------------------------------
package ins_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef logic [1:0] fault_t;

    localparam fault_t FAULT_OK       = 2'd0;
    localparam fault_t FAULT_MISALIGN = 2'd1;
    localparam fault_t FAULT_RANGE    = 2'd2;

    // log2 of the number of bytes per word; 0 for byte-wide words.
    function automatic int byte_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/ins_mem_array.sv
// ---------------------------------------------------------------------------
// ins_mem_array
// DEPTH x DATA_W storage, no reset.
//   clk    : clock
//   we     : write enable      waddr : word index   wdata : word to store
//   re     : read enable       raddr : word index
//   rdata  : registered read data, updated only when re is high and
//            holding its value otherwise
// A read and a write to the same index in the same cycle return the old
// word (read-before-write); both sit in one clocked block so the read
// samples the array before the non-blocking write lands.
// ---------------------------------------------------------------------------
module ins_mem_array
    import ins_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ins_mem_sync.sv
// ---------------------------------------------------------------------------
// ins_mem_sync
// Clocked instruction memory with a registered fetch port, a program-load
// write port and a post-reset clear sequencer.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   ready        : high once every word has been zeroed (state RUN)
//   fetch_req    : fetch request, accepted only while ready
//   fetch_addr   : byte address (PC)
//   fetch_valid  : one-cycle pulse, one cycle after an accepted request
//   fetch_data   : instruction word (0 on any fault)
//   fetch_fault  : 0 ok, 1 misaligned, 2 out of range (misaligned wins)
//   load_en      : word write strobe, accepted only while ready
//   load_idx     : word index to write
//   load_data    : word to write
// fetch_data / fetch_fault hold their last response while no request is
// accepted.
// ---------------------------------------------------------------------------
module ins_mem_sync
    import ins_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic [1:0]        fetch_fault,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [DATA_W-1:0] load_data
);

    localparam int OFF_W = byte_off_w(DATA_W);
    // First address bit above the word-index field.
    localparam int HI_LO = OFF_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              fetch_valid_q, fetch_valid_d;
    fault_t            fetch_fault_q, fetch_fault_d;
    // Set when the last accepted fetch returned array data; a fault or a
    // reset forces the visible word to zero without touching the array
    // read register (which has no reset).
    logic              data_sel_q, data_sel_d;

    // ------------------------------------------------------------------
    // Fetch address decode
    // ------------------------------------------------------------------
    logic              misalign;
    logic              out_of_range;
    logic [IDX_W-1:0]  fetch_idx;
    fault_t            fetch_code;
    logic              fetch_acc;
    logic              load_acc;

    generate
        if (OFF_W > 0) begin : g_off
            assign misalign = |fetch_addr[OFF_W-1:0];
        end else begin : g_no_off
            assign misalign = 1'b0;
        end

        if (HI_LO < ADDR_W) begin : g_hi
            assign out_of_range = |fetch_addr[ADDR_W-1:HI_LO];
        end else begin : g_no_hi
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign fetch_idx = fetch_addr[HI_LO-1:OFF_W];

    always_comb begin
        fetch_code = FAULT_OK;
        if (misalign) begin
            fetch_code = FAULT_MISALIGN;
        end else if (out_of_range) begin
            fetch_code = FAULT_RANGE;
        end
    end

    assign fetch_acc = fetch_req && (state_q == RUN);
    assign load_acc  = load_en   && (state_q == RUN);

    // ------------------------------------------------------------------
    // Storage, write port shared between the clear sequencer and loads
    // ------------------------------------------------------------------
    logic              arr_we;
    logic [IDX_W-1:0]  arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic              arr_re;
    logic [DATA_W-1:0] arr_rdata;

    always_comb begin
        arr_we    = load_acc;
        arr_waddr = load_idx;
        arr_wdata = load_data;
        if (state_q == CLEAR) begin
            arr_we    = 1'b1;
            arr_waddr = clr_cnt_q;
            arr_wdata = '0;
        end
    end

    // Only clean fetches touch the read register, so it keeps the last
    // good word while faults and idle cycles go by.
    assign arr_re = fetch_acc && (fetch_code == FAULT_OK);

    ins_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (fetch_idx),
        .rdata (arr_rdata)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= CLEAR;
            clr_cnt_q     <= '0;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= FAULT_OK;
            data_sel_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_fault_q <= fetch_fault_d;
            data_sel_q    <= data_sel_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        fetch_valid_d = fetch_acc;
        fetch_fault_d = fetch_fault_q;
        data_sel_d    = data_sel_q;

        case (state_q)
            CLEAR: begin
                // The counter parks on the last index instead of wrapping.
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + IDX_W'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        if (fetch_acc) begin
            fetch_fault_d = fetch_code;
            data_sel_d    = (fetch_code == FAULT_OK);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready       = (state_q == RUN);
        fetch_valid = fetch_valid_q;
        fetch_fault = fetch_fault_q;
        fetch_data  = data_sel_q ? arr_rdata : '0;
    end

endmodule

// File: tb/tb_ins_mem_sync.sv
// ---------------------------------------------------------------------------
// tb_ins_mem_sync
// Main instance: DATA_W=32, ADDR_W=32, DEPTH=1024.
// Small instance: DATA_W=16, ADDR_W=16, DEPTH=8.
// The reference memory is a plain array; expected fetch results come from
// byte-address arithmetic (modulo for alignment, division for the index).
// ---------------------------------------------------------------------------
module tb_ins_mem_sync;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int DP = 1024;
    localparam int BPW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ready;
    logic              fetch_req;
    logic [AW-1:0]     fetch_addr;
    logic              fetch_valid;
    logic [DW-1:0]     fetch_data;
    logic [1:0]        fetch_fault;
    logic              load_en;
    logic [9:0]        load_idx;
    logic [DW-1:0]     load_data;

    logic              s_rst_n;
    logic              s_ready;
    logic              s_fetch_req;
    logic [15:0]       s_fetch_addr;
    logic              s_fetch_valid;
    logic [15:0]       s_fetch_data;
    logic [1:0]        s_fetch_fault;
    logic              s_load_en;
    logic [2:0]        s_load_idx;
    logic [15:0]       s_load_data;

    always #5 clk = ~clk;

    ins_mem_sync #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ready       (ready),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_fault (fetch_fault),
        .load_en     (load_en),
        .load_idx    (load_idx),
        .load_data   (load_data)
    );

    ins_mem_sync #(.DATA_W(16), .ADDR_W(16), .DEPTH(8)) dut_s (
        .clk         (clk),
        .rst_n       (s_rst_n),
        .ready       (s_ready),
        .fetch_req   (s_fetch_req),
        .fetch_addr  (s_fetch_addr),
        .fetch_valid (s_fetch_valid),
        .fetch_data  (s_fetch_data),
        .fetch_fault (s_fetch_fault),
        .load_en     (s_load_en),
        .load_idx    (s_load_idx),
        .load_data   (s_load_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] ref_mem [DP];
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_fault;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    function automatic logic [33:0] model_fetch(input logic [31:0] a);
        if ((a % BPW) != 0) return {2'd1, 32'd0};
        if ((a / BPW) >= DP) return {2'd2, 32'd0};
        return {2'd0, ref_mem[a / BPW]};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DP; i++) ref_mem[i] = '0;
        exp_data  = '0;
        exp_fault = 2'd0;
    endtask

    // One cycle of stimulus on the main instance, then check its response.
    task automatic cyc(input bit req, input logic [31:0] addr, input bit ld,
                       input int ld_i, input logic [31:0] ld_d, input string tag);
        logic [33:0] e;
        logic [9:0]  li;
        li         = 10'(ld_i);
        fetch_req  = req;
        fetch_addr = addr;
        load_en    = ld;
        load_idx   = li;
        load_data  = ld_d;
        if (req) begin
            e         = model_fetch(addr);
            exp_fault = e[33:32];
            exp_data  = e[31:0];
        end
        @(posedge clk);
        #1;
        if (ld) ref_mem[li] = ld_d;
        fetch_req = 1'b0;
        load_en   = 1'b0;
        chk({tag, ".valid"}, 64'(fetch_valid), 64'(req));
        chk({tag, ".fault"}, 64'(fetch_fault), 64'(exp_fault));
        chk({tag, ".data"},  64'(fetch_data),  64'(exp_data));
    endtask

    // Count cycles from reset release until ready, with random traffic
    // that must be ignored throughout the clear.
    task automatic count_clear(input string tag);
        int n;
        int vseen;
        n     = 0;
        vseen = 0;
        while (!ready && n < 3000) begin
            fetch_req  = 1'($urandom);
            fetch_addr = 32'($urandom_range(0, 255) * 4);
            load_en    = 1'($urandom);
            load_idx   = 10'($urandom);
            load_data  = $urandom;
            @(posedge clk);
            #1;
            n++;
            if (fetch_valid) vseen++;
        end
        fetch_req = 1'b0;
        load_en   = 1'b0;
        chk({tag, ".clear_cycles"}, 64'(n), 64'(DP));
        chk({tag, ".valid_in_clear"}, 64'(vseen), 64'd0);
        chk({tag, ".ready"}, 64'(ready), 64'd1);
    endtask

    task automatic s_fetch(input logic [15:0] a, input logic [1:0] ef,
                           input logic [15:0] ed, input string tag);
        s_fetch_req  = 1'b1;
        s_fetch_addr = a;
        @(posedge clk);
        #1;
        s_fetch_req = 1'b0;
        chk({tag, ".valid"}, 64'(s_fetch_valid), 64'd1);
        chk({tag, ".fault"}, 64'(s_fetch_fault), 64'(ef));
        chk({tag, ".data"},  64'(s_fetch_data),  64'(ed));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        int r;
        int li;

        rst_n = 1'b0;   s_rst_n = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0; load_en = 1'b0; load_idx = '0; load_data = '0;
        s_fetch_req = 1'b0; s_fetch_addr = '0; s_load_en = 1'b0; s_load_idx = '0; s_load_data = '0;
        clear_model();

        #12;
        chk("rst.ready", 64'(ready), 64'd0);
        chk("rst.valid", 64'(fetch_valid), 64'd0);
        chk("rst.data",  64'(fetch_data), 64'd0);
        chk("rst.fault", 64'(fetch_fault), 64'd0);
        chk("s_rst.ready", 64'(s_ready), 64'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_clear("init");

        // Directed fetch/load sequence.
        cyc(0, 0, 1, 4, 32'd32,  "load4");
        cyc(0, 0, 1, 5, 32'd456, "load5");
        cyc(1, 32'd16, 0, 0, 0, "f16");
        cyc(1, 32'd20, 0, 0, 0, "f20");
        cyc(1, 32'd24, 0, 0, 0, "f24");
        cyc(1, 32'h12, 0, 0, 0, "f12_misalign");
        cyc(0, 0, 0, 0, 0, "idle_hold");
        cyc(1, 32'h1000, 0, 0, 0, "f1000_range");
        cyc(1, 32'h1001, 0, 0, 0, "f1001_prio");
        cyc(1, 32'd28, 1, 7, 32'hDEADBEEF, "rbw_old");
        cyc(1, 32'd28, 0, 0, 0, "rbw_new");
        cyc(1, 32'hFFC, 0, 0, 0, "f_last_word");

        // Randomised traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = 32'($urandom_range(0, 31) * 4);
            else if (r < 8)  a = 32'($urandom_range(0, 1023) * 4 + $urandom_range(1, 3));
            else             a = $urandom;
            li = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023))
                                             : int'($urandom_range(0, 31));
            cyc($urandom_range(0, 3) != 0, a, 1'($urandom), li, $urandom, "rnd");
        end

        // Reset while a response is on the outputs.
        cyc(0, 0, 1, 4, 32'h1234_5678, "pre_rst_load");
        fetch_req  = 1'b1;
        fetch_addr = 32'd16;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        chk("rst2.pending_valid", 64'(fetch_valid), 64'd1);
        chk("rst2.pending_data",  64'(fetch_data), 64'h1234_5678);
        rst_n = 1'b0;
        #1;
        chk("rst2.valid", 64'(fetch_valid), 64'd0);
        chk("rst2.ready", 64'(ready), 64'd0);
        chk("rst2.data",  64'(fetch_data), 64'd0);
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_clear("rerun");
        cyc(1, 32'd16, 0, 0, 0, "post_rst16");
        cyc(1, 32'd20, 0, 0, 0, "post_rst20");
        cyc(1, 32'd28, 0, 0, 0, "post_rst28");

        // Small configuration: 16-bit words, 8 entries.
        @(posedge clk);
        #1;
        s_rst_n = 1'b1;
        begin
            int n;
            n = 0;
            while (!s_ready && n < 100) begin
                s_fetch_req = 1'($urandom);
                @(posedge clk);
                #1;
                n++;
            end
            s_fetch_req = 1'b0;
            chk("small.clear_cycles", 64'(n), 64'd8);
        end
        s_load_en   = 1'b1;
        s_load_idx  = 3'd7;
        s_load_data = 16'hBEEF;
        @(posedge clk);
        #1;
        s_load_en = 1'b0;
        chk("small.load_valid", 64'(s_fetch_valid), 64'd0);
        s_fetch(16'd14, 2'd0, 16'hBEEF, "small.f14");
        s_fetch(16'd16, 2'd2, 16'h0000, "small.f16");
        s_fetch(16'd15, 2'd1, 16'h0000, "small.f15");
        s_fetch(16'd2,  2'd0, 16'h0000, "small.f2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
